// File: rtl/usb_fe_rx.sv
// rtl/usb_fe_rx.sv - USB full-speed receive front end: line sync, clock recovery, NRZI/destuff, packet framing
//
// Ports:
//   clk        48 MHz sampling clock (4x full-speed bit rate)
//   rst_n      synchronous active-low reset
//   dp, dn     asynchronous USB D+/D- lines
//   rx_active  high from SYNC detection until end of packet (or abort recovery)
//   rx_data    last received byte, LSB received first
//   rx_valid   one-clk strobe, rx_data valid in the same cycle
//   rx_eop     one-clk strobe on a good end of packet
//   rx_err     one-clk strobe on a packet error
//   bus_rst    level, high while SE0 has persisted for RST_CYCLES clocks
//
// Optional feature macro: USB_FE_RX_STUFF_ERR_EN
//   defined   : a 1 in a stuff-bit position raises rx_err and aborts the packet
//   undefined : the stuff-bit position is dropped unconditionally
module usb_fe_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp,
  input  logic       dn,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       bus_rst
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} ls_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ABORT} state_t;

  logic [SYNC_STAGES-1:0] dp_sync;
  logic [SYNC_STAGES-1:0] dn_sync;
  ls_t                    ls;
  ls_t                    ls_q;
  ls_t                    prev_smp;
  ls_t                    prev_d;
  logic [1:0]             phase;
  logic                   sample;
  logic                   nrzi_bit;
  logic [CW-1:0]          se0_cnt;

  state_t     state, state_d;
  logic [2:0] zc, zc_d;
  logic [2:0] ones, ones_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] sr, sr_d;
  logic [7:0] data_d;
  logic       valid_d, eop_d, err_d;
  logic       seen_se0, seen_se0_d;

  // Line state decode; SE1 is folded into SE0.
  always_comb begin
    case ({dp_sync[SYNC_STAGES-1], dn_sync[SYNC_STAGES-1]})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      default: ls = LS_SE0;
    endcase
  end

  // Mid-bit sample point: second clock after the last line-state change.
  assign sample    = (phase == 2'd1);
  assign nrzi_bit  = (ls == prev_smp);
  assign bus_rst   = (se0_cnt == CW'(RST_CYCLES));
  assign rx_active = (state == ST_DATA) || (state == ST_EOP) || (state == ST_ABORT);

  always_comb begin
    state_d    = state;
    zc_d       = zc;
    ones_d     = ones;
    bit_cnt_d  = bit_cnt;
    sr_d       = sr;
    data_d     = rx_data;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    seen_se0_d = seen_se0;
    prev_d     = prev_smp;

    if (bus_rst) begin
      state_d = ST_IDLE;
    end else if (sample) begin
      if (ls != LS_SE0) prev_d = ls;
      case (state)
        ST_IDLE: begin
          // The first K is itself a decoded 0 of the SYNC pattern.
          if (ls == LS_K) begin
            state_d = ST_SYNC;
            zc_d    = 3'd1;
          end
        end
        ST_SYNC: begin
          if (ls == LS_SE0) begin
            state_d = ST_IDLE;
          end else if (!nrzi_bit) begin
            zc_d = (zc == 3'd7) ? zc : zc + 3'd1;
          end else if (zc >= 3'd5) begin
            state_d   = ST_DATA;
            ones_d    = 3'd1;  // the SYNC trailing 1 counts toward bit stuffing
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (ls == LS_SE0) begin
            state_d = ST_EOP;
          end else if (ones == 3'd6) begin
`ifdef USB_FE_RX_STUFF_ERR_EN
            if (nrzi_bit) begin
              err_d      = 1'b1;
              state_d    = ST_ABORT;
              seen_se0_d = 1'b0;
            end else begin
              ones_d = 3'd0;
            end
`else
            ones_d = 3'd0;
`endif
          end else begin
            ones_d    = nrzi_bit ? ones + 3'd1 : 3'd0;
            sr_d      = {nrzi_bit, sr[7:1]};
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_d  = sr_d;
              valid_d = 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (ls == LS_J) begin
            state_d = ST_IDLE;
            if (bit_cnt == 3'd0) eop_d = 1'b1;
            else                 err_d = 1'b1;
          end else if (ls == LS_K) begin
            state_d    = ST_ABORT;
            err_d      = 1'b1;
            seen_se0_d = 1'b0;
          end
        end
        ST_ABORT: begin
          if (ls == LS_SE0)                state_d = state;
          else if (ls == LS_J && seen_se0) state_d = ST_IDLE;
          if (ls == LS_SE0) seen_se0_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_IDLE) prev_d = LS_J;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_sync  <= '1;
      dn_sync  <= '0;
      ls_q     <= LS_J;
      phase    <= 2'd0;
      se0_cnt  <= '0;
      state    <= ST_IDLE;
      zc       <= 3'd0;
      ones     <= 3'd0;
      bit_cnt  <= 3'd0;
      sr       <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_err   <= 1'b0;
      seen_se0 <= 1'b0;
      prev_smp <= LS_J;
    end else begin
      if (SYNC_STAGES > 1) begin
        dp_sync <= {dp_sync[SYNC_STAGES-2:0], dp};
        dn_sync <= {dn_sync[SYNC_STAGES-2:0], dn};
      end
      ls_q  <= ls;
      phase <= (ls != ls_q) ? 2'd0 : phase + 2'd1;
      if (ls != LS_SE0)               se0_cnt <= '0;
      else if (se0_cnt != CW'(RST_CYCLES)) se0_cnt <= se0_cnt + CW'(1);
      state    <= state_d;
      zc       <= zc_d;
      ones     <= ones_d;
      bit_cnt  <= bit_cnt_d;
      sr       <= sr_d;
      rx_data  <= data_d;
      rx_valid <= valid_d;
      rx_eop   <= eop_d;
      rx_err   <= err_d;
      seen_se0 <= seen_se0_d;
      prev_smp <= prev_d;
    end
  end

endmodule

// File: tb/tb_usb_fe_rx.sv
// tb/tb_usb_fe_rx.sv - self-checking bench for usb_fe_rx
`timescale 1ps/1ps
module tb_usb_fe_rx;

  localparam int CLK_HALF = 10417;
  localparam int BIT_PS   = 8 * CLK_HALF;
`ifdef USB_FE_RX_STUFF_ERR_EN
  localparam bit STUFF_ERR = 1'b1;
`else
  localparam bit STUFF_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dp = 1'b1;
  logic       dn = 1'b0;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_err;
  logic       bus_rst;

  usb_fe_rx #(.SYNC_STAGES(2), .RST_CYCLES(120)) dut (
    .clk(clk), .rst_n(rst_n), .dp(dp), .dn(dn),
    .rx_active(rx_active), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_eop(rx_eop), .rx_err(rx_err), .bus_rst(bus_rst)
  );

  always #CLK_HALF clk = ~clk;

  typedef struct {
    int         kind;   // 0 byte, 1 good eop, 2 error
    logic [7:0] data;
    logic       active;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  bit   data_q[$];
  bit   wire_q[$];
  int   n_valid, n_eop, n_err;
  logic [7:0] last_data;
  bit   jitter_en = 1'b0;
  logic [2:0] prev_s = 3'b000;
  logic [2:0] cur_s;
  ev_t  cur_ev;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int kind_mask(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  // Compare process: every strobe must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      cur_s = {rx_valid, rx_eop, rx_err};
      if (cur_s != 3'b000) begin
        if (prev_s != 3'b000) check("strobe_consecutive", int'(prev_s), 0);
        if (rx_valid) begin n_valid++; last_data = rx_data; end
        if (rx_eop) n_eop++;
        if (rx_err) n_err++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", int'(cur_s), 0);
        end else begin
          cur_ev = exp_q.pop_front();
          check("strobe_kind", int'(cur_s), kind_mask(cur_ev.kind));
          if (cur_ev.kind == 0) check("rx_data", int'(rx_data), int'(cur_ev.data));
          check("rx_active_at_strobe", int'(rx_active), int'(cur_ev.active));
        end
      end
      prev_s = cur_s;
    end else begin
      prev_s = 3'b000;
    end
  end

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) data_q.push_back(v[i]);
  endtask

  // Encoder side: insert a 0 after every six consecutive 1s (SYNC's last 1 included).
  task automatic stuff_data();
    int ones = 1;
    wire_q.delete();
    foreach (data_q[i]) begin
      wire_q.push_back(data_q[i]);
      ones = data_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        wire_q.push_back(1'b0);
        ones = 0;
      end
    end
    data_q.delete();
  endtask

  // Receiver rules: destuff, group into bytes, check residual at EOP.
  task automatic predict();
    int ones = 1;
    int cnt = 0;
    logic [7:0] sr = 8'h00;
    bit aborted = 1'b0;
    bit b;
    ev_t e;
    exp_q.delete();
    foreach (wire_q[i]) begin
      b = wire_q[i];
      if (ones == 6) begin
        if (b && STUFF_ERR) begin
          e.kind = 2; e.data = 8'h00; e.active = 1'b1;
          exp_q.push_back(e);
          aborted = 1'b1;
          break;
        end
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        sr = {b, sr[7:1]};
        cnt++;
        if (cnt % 8 == 0) begin
          e.kind = 0; e.data = sr; e.active = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
    if (!aborted) begin
      e.kind = (cnt % 8 == 0) ? 1 : 2; e.data = 8'h00; e.active = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input int ls, input int dur);
    case (ls)
      0:       {dp, dn} = 2'b10;
      1:       {dp, dn} = 2'b01;
      default: {dp, dn} = 2'b00;
    endcase
    #(dur);
  endtask

  function automatic int bitdur();
    return jitter_en ? BIT_PS - 100 + int'($urandom_range(0, 200)) : BIT_PS;
  endfunction

  task automatic send_wire(input int eop_bits);
    int lvl = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 7) lvl = 1 - lvl;
      drive(lvl, bitdur());
    end
    foreach (wire_q[i]) begin
      if (!wire_q[i]) lvl = 1 - lvl;
      drive(lvl, bitdur());
    end
    for (int i = 0; i < eop_bits; i++) drive(2, bitdur());
    drive(0, 6 * BIT_PS);
  endtask

  task automatic run_packet(input string name, input int eop_bits);
    predict();
    n_valid = 0; n_eop = 0; n_err = 0;
    send_wire(eop_bits);
    check({name, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_active_after"}, int'(rx_active), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_active"}, int'(rx_active), 0);
    check({name, "_rx_data"},   int'(rx_data),   0);
    check({name, "_strobes"},   int'({rx_valid, rx_eop, rx_err}), 0);
    check({name, "_bus_rst"},   int'(bus_rst),   0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte A5, nominal rate.
    push_byte(8'hA5); stuff_data();
    run_packet("a5", 2);
    check("a5_n_valid", n_valid, 1);
    check("a5_data", int'(last_data), 8'hA5);
    check("a5_n_eop", n_eop, 1);
    check("a5_n_err", n_err, 0);

    // FF FF with stuffing and jittered bit period.
    jitter_en = 1'b1;
    push_byte(8'hFF); push_byte(8'hFF); stuff_data();
    run_packet("ffff", 2);
    jitter_en = 1'b0;
    check("ffff_n_valid", n_valid, 2);
    check("ffff_data", int'(last_data), 8'hFF);
    check("ffff_n_eop", n_eop, 1);
    check("ffff_n_err", n_err, 0);

    // FF stuffed, then nine raw 1s: the stuff position carries a 1.
    push_byte(8'hFF); stuff_data();
    for (int i = 0; i < 9; i++) wire_q.push_back(1'b1);
    run_packet("stuff", 2);
    if (STUFF_ERR) begin
      check("stuff_n_valid", n_valid, 1);
      check("stuff_n_err", n_err, 1);
      check("stuff_n_eop", n_eop, 0);
    end else begin
      check("stuff_n_valid", n_valid, 2);
      check("stuff_n_err", n_err, 0);
      check("stuff_n_eop", n_eop, 1);
    end

    // 12 data bits: one byte then a residual of 4.
    push_byte(8'hA5);
    data_q.push_back(1'b1); data_q.push_back(1'b0);
    data_q.push_back(1'b1); data_q.push_back(1'b0);
    stuff_data();
    run_packet("bits12", 2);
    check("bits12_n_valid", n_valid, 1);
    check("bits12_n_err", n_err, 1);
    check("bits12_n_eop", n_eop, 0);

    // Three-bit SE0 at end of packet is an ordinary EOP.
    push_byte(8'h3C); stuff_data();
    run_packet("se0x3", 3);
    check("se0x3_data", int'(last_data), 8'h3C);
    check("se0x3_n_eop", n_eop, 1);

    // Long SE0: bus reset.
    @(negedge clk);
    {dp, dn} = 2'b00;
    repeat (110) @(negedge clk);
    check("busrst_early", int'(bus_rst), 0);
    repeat (15) @(negedge clk);
    check("busrst_125", int'(bus_rst), 1);
    repeat (5) @(negedge clk);
    check("busrst_130", int'(bus_rst), 1);
    check("busrst_active", int'(rx_active), 0);
    {dp, dn} = 2'b10;
    repeat (5) @(negedge clk);
    check("busrst_release", int'(bus_rst), 0);
    repeat (20) @(negedge clk);

    // Reset during the second byte; only the first byte is reported.
    push_byte(8'h3C); push_byte(8'hFF); stuff_data();
    exp_q.delete();
    cur_ev.kind = 0; cur_ev.data = 8'h3C; cur_ev.active = 1'b1;
    exp_q.push_back(cur_ev);
    n_valid = 0; n_eop = 0; n_err = 0;
    fork
      send_wire(2);
      begin
        #(18 * BIT_PS + BIT_PS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
      end
    join
    check("midrst_pending", exp_q.size(), 0);
    check("midrst_n_valid", n_valid, 1);
    check("midrst_n_eop", n_eop, 0);
    check("midrst_n_err", n_err, 0);
    check("midrst_active", int'(rx_active), 0);

    push_byte(8'hA5); stuff_data();
    run_packet("after_rst", 2);
    check("after_rst_data", int'(last_data), 8'hA5);
    check("after_rst_n_eop", n_eop, 1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_fe_rx.md
USB_FE_RX -- requirements
Module: usb_fe_rx

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of input synchroniser flops on dp and dn (legal 2..3).
REQ-002 Parameter: RST_CYCLES, 120, consecutive SE0 clocks that signal a bus reset (2.5 us at 48 MHz).
REQ-003 clk  input  1  48 MHz sampling clock (4x FS bit rate); single clock domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 dp  input  1  asynchronous USB D+ line.
REQ-006 dn  input  1  asynchronous USB D- line.
REQ-007 rx_active  output  1  high from SYNC detection until end of packet.
REQ-008 rx_data  output  8  received byte, LSB received first.
REQ-009 rx_valid  output  1  one-clk strobe; rx_data is valid in the same cycle.
REQ-010 rx_eop  output  1  one-clk strobe on a good end of packet.
REQ-011 rx_err  output  1  one-clk strobe on a packet error.
REQ-012 bus_rst  output  1  level, high while SE0 has persisted for at least RST_CYCLES clocks.

Function
REQ-013 dp and dn shall each pass through SYNC_STAGES flops; line state decode: J=(1,0), K=(0,1), SE0=(0,0); SE1=(1,1) shall be treated as SE0.
REQ-014 Clock recovery: 2-bit phase counter, cleared on every synchronised line-state change, wrapping 3->0; a bit sample is taken when phase==1 after clear (mid-bit).
REQ-015 NRZI decode per sample: no change vs previous sample -> 1; change -> 0; the previous sample is J on entry to IDLE.
REQ-016 FSM states: IDLE, SYNC, DATA, EOP, ABORT.
REQ-017 IDLE: a K sample -> SYNC; all outputs idle.
REQ-018 SYNC: at least 5 consecutive decoded 0s followed by a 1 -> DATA, with rx_active asserted on the next clk; any other 1 or SE0 -> IDLE.
REQ-019 DATA: after six consecutive 1s the next bit is a stuff bit and shall be dropped; the ones counter clears on any 0 or stuff bit.
REQ-020 DATA: non-stuff bits shift into an 8-bit register LSB-first; on the 8th bit, rx_data loads and rx_valid pulses within 2 clk of that bit's sample.
REQ-021 DATA: an SE0 sample -> EOP.
REQ-022 EOP: a J sample -> IDLE; rx_active drops and either rx_eop or rx_err pulses in the same cycle.
REQ-023 EOP: rx_eop pulses if the residual bit count is 0 (mod 8); otherwise rx_err pulses and rx_eop does not.
REQ-024 EOP: a K sample -> ABORT with an rx_err pulse.
REQ-025 ABORT: rx_active stays high; SE0 followed by J -> IDLE, deasserting rx_active with no further strobes.
REQ-026 rx_valid, rx_eop and rx_err shall never be high for more than one consecutive clk.
REQ-027 The SE0 counter saturates at RST_CYCLES; bus_rst asserts when it is reached and clears on the first non-SE0 synchronised state.
REQ-028 bus_rst assertion shall force the FSM to IDLE and rx_active low with no strobes.

Reset
REQ-029 rst_n low at a clk edge: FSM=IDLE, rx_active=0, rx_data=8'h00, rx_valid=0, rx_eop=0, rx_err=0, bus_rst=0, all counters 0, and synchroniser and previous-sample registers = J.
REQ-030 Reset asserted mid-packet shall abandon the packet with no strobes; after release, reception resumes only at the next SYNC.

Configuration
REQ-031 Macro USB_FE_RX_STUFF_ERR_EN defined: a stuff-bit position carrying 1 (seventh consecutive 1) shall pulse rx_err and enter ABORT.
REQ-032 Macro USB_FE_RX_STUFF_ERR_EN undefined: the stuff-bit position is dropped unconditionally and no stuff error is reported.

Verification
REQ-033 SYNC + byte 8'hA5 + EOP (SE0,SE0,J) at nominal rate -> one rx_valid with rx_data=8'hA5, then rx_eop=1, rx_active low.
REQ-034 SYNC + bytes 8'hFF,8'hFF with stuffing, bit period jittered +/-100 ps -> rx_data 8'hFF twice, rx_eop, no rx_err.
REQ-035 SYNC + 8'hFF + forced seven 1s without a stuff transition -> rx_err pulse, ABORT until EOP; with USB_FE_RX_STUFF_ERR_EN undefined -> no rx_err.
REQ-036 SYNC + 12 data bits + EOP -> one rx_valid, rx_err at EOP, no rx_eop.
REQ-037 SE0 held 130 clk -> bus_rst high from clk 120 (after synchroniser delay) until J returns; mid-packet SE0 of 3 bits -> normal EOP handling.
REQ-038 rst_n pulsed low during the 2nd byte -> all outputs at reset values, no strobes; the next packet is received correctly.
